// File: rtl/branch_enc_pkg.sv
// branch_enc_pkg: shared widths and result type for the branch offset encoder
package branch_enc_pkg;
  localparam int IMM_W = 16;
  localparam int ADDR_W = 32;
  localparam int PC_INC_DEF = 4;
  typedef struct packed {
    logic [IMM_W-1:0] imm16;
    logic misaligned;
    logic range_err;
  } enc_result_t;
endpackage

// File: rtl/branch_range_check.sv
// branch_range_check: classifies a byte difference into an encoded immediate and error flags
module branch_range_check
  import branch_enc_pkg::*;
(
  input  logic [ADDR_W-1:0] diff,
  output enc_result_t       res
);
  logic mis;
  logic rng;
  always_comb begin
    mis = |diff[1:0];
    rng = ~(&diff[31:17] | ~|diff[31:17]);
    res.misaligned = mis;
    res.range_err = rng;
    res.imm16 = (mis | rng) ? '0 : diff[17:2];
  end
endmodule

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder: two-stage elastic pipeline turning (pc, target) into a branch immediate
module branch_offset_encoder
  import branch_enc_pkg::*;
#(
  parameter int PC_INC = PC_INC_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm16,
  output logic              out_misaligned,
  output logic              out_range_err,
  output logic [CNT_W-1:0]  err_count
);
  logic s1_valid;
  logic [ADDR_W-1:0] s1_diff;
  enc_result_t rc;
  enc_result_t res;
  logic s2_load;
  logic s1_load;
  branch_range_check u_rc (.diff(s1_diff), .res(rc));
  assign s2_load = s1_valid & (~out_valid | out_ready);
  assign s1_load = ~s1_valid | s2_load;
  assign in_ready = s1_load;
  assign out_imm16 = res.imm16;
  assign out_misaligned = res.misaligned;
  assign out_range_err = res.range_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff <= '0;
      out_valid <= 1'b0;
      res <= '0;
      err_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        s1_diff <= in_target - in_pc - ADDR_W'(PC_INC);
      end
      if (s2_load) begin
        out_valid <= 1'b1;
        res <= rc;
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid & out_ready & (res.misaligned | res.range_err) & ~&err_count)
        err_count <= err_count + CNT_W'(1);
    end
  end
endmodule
